// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: MEM/WB bundle layout and register file sizing shared by producer and writeback stage.
package wb_regfile_pkg;
    localparam int DATA_W  = 32;
    localparam int NREG    = 32;
    localparam int ADDR_W  = 5;
    localparam int MEMWB_W = 69;
    localparam int MEM_MSB = 68;
    localparam int MEM_LSB = 37;
    localparam int ALU_MSB = 36;
    localparam int ALU_LSB = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 0;

    function automatic logic [ADDR_W-1:0] memwb_rd(input logic [MEMWB_W-1:0] b);
        return b[RD_MSB:RD_LSB];
    endfunction
endpackage

// File: rtl/wb_regfile_array.sv
// regfile_array: architectural register storage with async clear, one write port and two combinational read ports.
module regfile_array #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int NREG   = wb_regfile_pkg::NREG
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we_i,
    input  logic [wb_regfile_pkg::ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]                 wdata_i,
    input  logic [wb_regfile_pkg::ADDR_W-1:0] raddr_a_i,
    input  logic [wb_regfile_pkg::ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]                 rdata_a_o,
    output logic [DATA_W-1:0]                 rdata_b_o
);
    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Register 0 is hardwired to zero regardless of what the storage holds.
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage with register file, write-through bypass and retired-writeback counter.
module wb_regfile #(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int NREG   = wb_regfile_pkg::NREG
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               Load,
    input  logic [wb_regfile_pkg::MEMWB_W-1:0] Din,
    input  logic                               RegWrite,
    input  logic                               MemtoReg,
    input  logic [wb_regfile_pkg::ADDR_W-1:0]  rs_addr,
    input  logic [wb_regfile_pkg::ADDR_W-1:0]  rt_addr,
    output logic [DATA_W-1:0]                  rs_data,
    output logic [DATA_W-1:0]                  rt_data,
    output logic [DATA_W-1:0]                  wb_data,
    output logic                               wb_we,
    output logic [31:0]                        retire_cnt
);
    import wb_regfile_pkg::*;

    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] arr_rs, arr_rt;
    logic [31:0]       retire_q, retire_d;

    assign rd      = memwb_rd(Din);
    assign wb_data = MemtoReg ? Din[MEM_MSB:MEM_LSB] : Din[ALU_MSB:ALU_LSB];
    assign wb_we   = Load & RegWrite & (rd != '0) & ~rst;

    regfile_array #(.DATA_W(DATA_W), .NREG(NREG)) u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we),
        .waddr_i   (rd),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rt_addr),
        .rdata_a_o (arr_rs),
        .rdata_b_o (arr_rt)
    );

    // Bypass lets decode see the value being written on this very edge.
    assign rs_data = (wb_we && rs_addr == rd) ? wb_data : arr_rs;
    assign rt_data = (wb_we && rt_addr == rd) ? wb_data : arr_rt;

    // Retirements count any committed RegWrite, including discarded writes to register 0.
    assign retire_d   = retire_q + 32'(Load & RegWrite);
    assign retire_cnt = retire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retire_q <= '0;
        else     retire_q <= retire_d;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;
    logic        clk = 1'b0, rst = 1'b1, Load = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
    logic [68:0] Din = '0;
    logic [4:0]  rs_addr = '0, rt_addr = '0;
    logic [31:0] rs_data, rt_data, wb_data, retire_cnt;
    logic        wb_we;
    int          tests = 0, fails = 0;
    logic [31:0] mregs [32];
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .Load       (Load),
        .Din        (Din),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
        .retire_cnt (retire_cnt)
    );

    function automatic logic [31:0] exp_wb();
        return MemtoReg ? Din[68:37] : Din[36:5];
    endfunction

    function automatic logic exp_we();
        return Load && RegWrite && Din[4:0] != 5'd0 && !rst;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst) return 32'd0;
        if (exp_we() && a == Din[4:0]) return exp_wb();
        return (a == 5'd0) ? 32'd0 : mregs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb_data"}, wb_data, exp_wb());
        chk({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, exp_we()});
        chk({tag, ".rs_data"}, rs_data, exp_rd(rs_addr));
        chk({tag, ".rt_data"}, rt_data, exp_rd(rt_addr));
        chk({tag, ".retire"}, retire_cnt, mcnt);
    endtask

    task automatic step(input string tag, input bit ld, input bit rw, input bit mtr,
                        input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        logic        we;
        logic [31:0] wv;
        Load = ld; RegWrite = rw; MemtoReg = mtr;
        Din = {mem, alu, rd}; rs_addr = rs; rt_addr = rt;
        #1;
        check_all(tag);
        we = exp_we();
        wv = exp_wb();
        @(posedge clk);
        if (!rst && ld && rw) mcnt++;
        if (we) mregs[rd] = wv;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] rd, rs, rt;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcnt = 32'd0;
        repeat (2) @(negedge clk);
        check_all("reset");
        step("rst_block", 1, 1, 0, 32'h0, 32'h11, 5'd4, 5'd4, 5'd4);
        rst = 1'b0;
        step("byp_5", 1, 1, 0, 32'hCAFE_0000, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
        step("read_5", 0, 0, 0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd4);
        step("wr_r0", 1, 1, 1, 32'hDEAD_BEEF, 32'h1, 5'd0, 5'd0, 5'd0);
        step("r0_after", 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
        step("noload_7", 0, 1, 0, 32'h0, 32'h55, 5'd7, 5'd7, 5'd7);
        step("read_7", 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        step("dual_byp_9", 1, 1, 0, 32'h0, 32'h77, 5'd9, 5'd9, 5'd9);
        step("b2b_a", 1, 1, 0, 32'h0, 32'h100, 5'd10, 5'd10, 5'd0);
        step("b2b_b", 1, 1, 1, 32'h200, 32'h0, 5'd10, 5'd10, 5'd10);
        step("b2b_read", 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd9);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        mcnt = 32'hFFFF_FFFF;
        step("wrap_pre", 1, 1, 0, 32'h0, 32'h3, 5'd11, 5'd11, 5'd0);
        step("wrap_post", 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd0);
        step("w3", 1, 1, 0, 32'h0, 32'hA5, 5'd3, 5'd3, 5'd0);
        Load = 1; RegWrite = 1; MemtoReg = 0; Din = {32'h0, 32'hBB, 5'd3}; rs_addr = 5'd3; rt_addr = 5'd9;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mcnt = 32'd0;
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_edge");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_read", 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd9);
        step("first_wr", 1, 1, 0, 32'h0, 32'h42, 5'd3, 5'd0, 5'd3);
        step("first_rd", 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            rs = ($urandom % 3 == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom % 3 == 0) ? rd : 5'($urandom_range(0, 31));
            step("rand", ($urandom % 4) != 0, ($urandom % 3) != 0, $urandom % 2,
                 $urandom, $urandom, rd, rs, rt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
